acl_spi_reader: RTL and testbench

- SPI mode-0 master that configures the ADXL362 accelerometer on the Nexys A7 and reads it periodically.
- Reads the 8-bit X/Y/Z MSB registers and packs them into the 15-bit sign/magnitude word consumed by the seven-segment display driver.
- Sits between the board SPI pins and the display path.
- Runs continuously after reset; no software interface.

---
 rtl/acl_spi_reader.sv | 198 +++++++++++++++++++
 tb/tb_acl_spi_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/acl_spi_reader.sv
// ADXL362 SPI mode-0 master: one POWER_CTL config write after reset, then periodic
// X/Y/Z MSB reads packed into the 15-bit sign/magnitude word for the display path.
module acl_spi_reader #(
  parameter int unsigned CLK_DIV        = 50,
  parameter int unsigned STARTUP_CYCLES = 600_000,
  parameter int unsigned SAMPLE_CYCLES  = 1_000_000
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic [14:0] acl_data,
  output logic        data_valid,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_STARTUP, ST_CFG, ST_GAP, ST_WAIT, ST_READ, ST_UPDATE
  } state_t;

  typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_TAIL} phase_t;

  localparam logic [39:0] CFG_WORD  = {24'h0A2D02, 16'h0000};
  localparam logic [39:0] READ_WORD = {16'h0B08, 24'h000000};

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] tx_q, tx_d;
  logic [23:0] rx_q, rx_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic [14:0] acl_data_q, acl_data_d;
  logic        data_valid_q, data_valid_d;
  logic        miso_s1_q, miso_s1_d;
  logic        miso_s2_q, miso_s2_d;

  logic        start_xfer;
  logic [39:0] start_word;
  logic        xfer_done;
  logic        div_end;
  logic [5:0]  last_bit;

  // |v| is formed in 9 bits so -128 becomes 128 before the shift and saturation.
  function automatic logic [4:0] pack_axis(input logic [7:0] v);
    logic [8:0] mag9;
    logic [6:0] q;
    mag9 = v[7] ? (9'd0 - {v[7], v}) : {1'b0, v};
    q    = mag9[8:2];
    return {v[7], (q > 7'd15) ? 4'hF : q[3:0]};
  endfunction

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    cs_n_d       = cs_n_q;
    acl_data_d   = acl_data_q;
    data_valid_d = 1'b0;
    miso_s1_d    = miso;
    miso_s2_d    = miso_s1_q;
    start_xfer   = 1'b0;
    start_word   = CFG_WORD;
    xfer_done    = 1'b0;
    div_end      = (cnt_q == 32'(CLK_DIV - 1));
    last_bit     = (state_q == ST_READ) ? 6'd39 : 6'd23;

    case (state_q)
      ST_STARTUP: begin
        if (cnt_q == 32'(STARTUP_CYCLES - 1)) begin
          state_d    = ST_CFG;
          start_xfer = 1'b1;
          start_word = CFG_WORD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_CFG, ST_READ: begin
        cnt_d = div_end ? 32'd0 : cnt_q + 32'd1;
        case (phase_q)
          PH_LOW: begin
            if (div_end) begin
              sclk_d  = 1'b1;
              phase_d = PH_HIGH;
            end
          end
          PH_HIGH: begin
            // Sample at the end of the first high cycle: the synchroniser output
            // then reflects miso from at least two cycles after the last sclk fall.
            if (cnt_q == 32'd0) rx_d = {rx_q[22:0], miso_s2_q};
            if (div_end) begin
              sclk_d = 1'b0;
              if (bit_cnt_q == last_bit) begin
                phase_d = PH_TAIL;
                mosi_d  = 1'b0;
              end else begin
                phase_d   = PH_LOW;
                bit_cnt_d = bit_cnt_q + 6'd1;
                mosi_d    = tx_q[39];
                tx_d      = {tx_q[38:0], 1'b0};
              end
            end
          end
          default: begin
            if (div_end) begin
              cs_n_d    = 1'b1;
              xfer_done = 1'b1;
            end
          end
        endcase
        if (xfer_done) state_d = (state_q == ST_CFG) ? ST_GAP : ST_UPDATE;
      end
      ST_GAP: begin
        if (cnt_q == 32'(2 * CLK_DIV - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 32'(SAMPLE_CYCLES - 1)) begin
          state_d    = ST_READ;
          start_xfer = 1'b1;
          start_word = READ_WORD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_UPDATE: begin
        acl_data_d   = {pack_axis(rx_q[23:16]), pack_axis(rx_q[15:8]), pack_axis(rx_q[7:0])};
        data_valid_d = 1'b1;
        state_d      = ST_GAP;
        cnt_d        = 32'd0;
      end
      default: state_d = ST_STARTUP;
    endcase

    if (start_xfer) begin
      cnt_d     = 32'd0;
      bit_cnt_d = 6'd0;
      phase_d   = PH_LOW;
      sclk_d    = 1'b0;
      cs_n_d    = 1'b0;
      mosi_d    = start_word[39];
      tx_d      = {start_word[38:0], 1'b0};
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_STARTUP;
      phase_q      <= PH_LOW;
      cnt_q        <= 32'd0;
      bit_cnt_q    <= 6'd0;
      tx_q         <= 40'd0;
      rx_q         <= 24'd0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      acl_data_q   <= 15'd0;
      data_valid_q <= 1'b0;
      miso_s1_q    <= 1'b0;
      miso_s2_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      acl_data_q   <= acl_data_d;
      data_valid_q <= data_valid_d;
      miso_s1_q    <= miso_s1_d;
      miso_s2_q    <= miso_s2_d;
    end
  end

  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;
  assign acl_data   = acl_data_q;
  assign data_valid = data_valid_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_acl_spi_reader.sv
// Bench for acl_spi_reader: SPI slave model plus a transaction-level reference that
// predicts config/read framing, packed display words and the read period.
module tb_acl_spi_reader;

  localparam int D      = 4;
  localparam int S_UP   = 20;
  localparam int S_SMP  = 50;
  localparam int PERIOD = 80 * D + D + 2 * D + S_SMP + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miso = 1'b0;
  logic        sclk, mosi, cs_n, data_valid;
  logic [14:0] acl_data;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard and slave-model state shared by the monitor and the driver.
  logic [14:0] exp_q[$];
  logic [23:0] xyz_q[$];
  logic [14:0] model_acl;
  int          cyc = 0;
  int          pending_due = -1;
  int          txn_idx = 0;
  int          rises = 0;
  int          run = 0;
  int          cs_hi = 0;
  int          since = 0;
  int          last_read_start = -1;
  bit          in_xfer = 0;
  bit          is_read = 0;
  logic [39:0] slave_word;
  logic [39:0] mosi_cap;
  logic [23:0] xyz_cur;

  acl_spi_reader #(
    .CLK_DIV(D), .STARTUP_CYCLES(S_UP), .SAMPLE_CYCLES(S_SMP)
  ) dut (
    .ClkPort(clk), .Reset(rst), .miso(miso), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .acl_data(acl_data), .data_valid(data_valid), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [4:0] pack_axis(input logic [7:0] v);
    int s, a, m;
    s = int'($signed(v));
    a = (s < 0) ? -s : s;
    m = a / 4;
    if (m > 15) m = 15;
    return {v[7], 4'(m)};
  endfunction

  function automatic logic [14:0] pack3(input logic [23:0] xyz);
    return {pack_axis(xyz[23:16]), pack_axis(xyz[15:8]), pack_axis(xyz[7:0])};
  endfunction

  // Monitor, slave model and per-cycle compare
  initial begin : monitor
    logic prev_cs, prev_sclk;
    prev_cs   = 1'b1;
    prev_sclk = 1'b0;
    model_acl = 15'd0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        since = 0; model_acl = 15'd0; exp_q.delete(); pending_due = -1;
        txn_idx = 0; in_xfer = 0; last_read_start = -1; cs_hi = 0; miso = 1'b0;
        prev_cs = 1'b1; prev_sclk = 1'b0;
      end else begin
        since++;
        check("data_valid", data_valid, cyc == pending_due);
        if (data_valid && exp_q.size() > 0) model_acl = exp_q.pop_front();
        check("acl_data", acl_data, model_acl);
        if (cs_n) begin
          check("sclk_idle", sclk, 1'b0);
          cs_hi++;
        end
        if (prev_cs && !cs_n) begin
          if (txn_idx == 0) check("startup_len", since, S_UP);
          else check("cs_gap_min", cs_hi >= 2 * D, 1'b1);
          is_read = (txn_idx != 0);
          if (is_read) begin
            if (last_read_start >= 0) check("read_period", cyc - last_read_start, PERIOD);
            last_read_start = cyc;
            xyz_cur = (xyz_q.size() > 0) ? xyz_q.pop_front() : 24'($urandom);
            slave_word = {16'($urandom_range(0, 65535)), xyz_cur};
          end else begin
            slave_word = {$urandom, 8'($urandom_range(0, 255))};
          end
          miso = slave_word[39];
          rises = 0; run = 1; mosi_cap = 40'd0; in_xfer = 1; cs_hi = 0;
        end else if (in_xfer && !cs_n) begin
          if (sclk != prev_sclk) begin
            check("sclk_phase_len", run, D);
            run = 1;
            if (sclk) begin
              mosi_cap = {mosi_cap[38:0], mosi};
              rises++;
            end else if (rises < 40) begin
              miso = slave_word[39 - rises];
            end
          end else begin
            run++;
          end
        end else if (in_xfer && cs_n) begin
          check("tail_len", run, D);
          in_xfer = 0;
          if (is_read) begin
            check("read_rises", rises, 40);
            check("read_cmd", mosi_cap, {16'h0B08, 24'h000000});
            exp_q.push_back(pack3(xyz_cur));
            pending_due = cyc + 1;
          end else begin
            check("cfg_rises", rises, 24);
            check("cfg_bytes", mosi_cap, {16'h0000, 24'h0A2D02});
          end
          txn_idx++;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
      end
    end
  end

  task automatic check_idle(input string name);
    check({name, "_cs_n"}, cs_n, 1'b1);
    check({name, "_sclk"}, sclk, 1'b0);
    check({name, "_mosi"}, mosi, 1'b0);
    check({name, "_acl"}, acl_data, 15'h0000);
    check({name, "_dv"}, data_valid, 1'b0);
  endtask

  task automatic wait_dv(input string name, input logic [14:0] exp);
    bit got;
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (data_valid) begin
        got = 1;
        break;
      end
    end
    check({name, "_seen"}, got, 1'b1);
    if (got) check(name, acl_data, exp);
  endtask

  // Driver
  initial begin : driver
    logic [23:0] t [3];
    bit found;

    check("pin_pack_a", pack3(24'h10F040), 15'b0_0100_1_0100_0_1111);
    check("pin_pack_b", pack3(24'h807F00), 15'b1_1111_0_1111_0_0000);
    check("pin_pack_c", pack3(24'hFF01FE), 15'b1_0000_0_0000_1_0000);

    repeat (5) @(negedge clk);
    check_idle("reset_hold");
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_idle("idle");
    #1 rst = 1'b1;
    #1 check_idle("reset_idle");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    xyz_q.push_back(24'h10F040);
    xyz_q.push_back(24'h807F00);
    xyz_q.push_back(24'hFF01FE);
    wait_dv("read_a", 15'b0_0100_1_0100_0_1111);
    wait_dv("read_b", 15'b1_1111_0_1111_0_0000);
    wait_dv("read_c", 15'b1_0000_0_0000_1_0000);

    xyz_q.push_back(24'($urandom));
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (in_xfer && is_read && rises == 20) begin
        found = 1;
        break;
      end
    end
    check("mid_read_reached", found, 1'b1);
    rst = 1'b1;
    #1 check_idle("reset_mid_read");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      t[i] = 24'($urandom);
      xyz_q.push_back(t[i]);
    end
    for (int i = 0; i < 3; i++) wait_dv($sformatf("rand_read%0d", i), pack3(t[i]));

    repeat (20) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
